// File: rtl/rv_thread_issue_if.sv
// Issue-stage bundle: ring enable, thread control strobes, issue outputs.
// Optional slot_err output exists only when RV_SLOT_CHECK_EN is defined.
interface rv_thread_issue_if #(
  parameter int NTHR  = 8,
  parameter int TID_W = 3
);
  logic [NTHR-1:0]  L_en;
  logic             thr_start;
  logic [TID_W-1:0] thr_start_id;
  logic             thr_pause;
  logic [TID_W-1:0] thr_pause_id;
  logic [NTHR-1:0]  thr_resume;
  logic [NTHR-1:0]  thr_kill;
  logic             issue_vld;
  logic [TID_W-1:0] issue_tid;
  logic [NTHR-1:0]  thr_run;
  logic [NTHR-1:0]  thr_busy;
  logic             start_nack;
`ifdef RV_SLOT_CHECK_EN
  logic             slot_err;
`endif

  modport master (
    output L_en, thr_start, thr_start_id,
    output thr_pause, thr_pause_id,
    output thr_resume, thr_kill,
    input  issue_vld, issue_tid,
    input  thr_run, thr_busy, start_nack
`ifdef RV_SLOT_CHECK_EN
    , input slot_err
`endif
  );

  modport slave (
    input  L_en, thr_start, thr_start_id,
    input  thr_pause, thr_pause_id,
    input  thr_resume, thr_kill,
    output issue_vld, issue_tid,
    output thr_run, thr_busy, start_nack
`ifdef RV_SLOT_CHECK_EN
    , output slot_err
`endif
  );
endinterface

// File: rtl/rv_thread_issue.sv
// Per-slot thread issue stage: FREE/RUN/PAUSED per thread, registered issue.
// Define RV_SLOT_CHECK_EN to add the sticky slot_err one-hot check.
module rv_thread_issue #(
  parameter int NTHR  = 8,
  parameter int TID_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  rv_thread_issue_if.slave bus
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } thr_st_e;

  thr_st_e          st_q [NTHR];
  thr_st_e          st_d [NTHR];
  logic             vld_q, vld_d;
  logic [TID_W-1:0] tid_q, tid_d;
  logic             nack_q, nack_d;
  logic [TID_W-1:0] sel_tid;
  logic             sel_hit;

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      st_d[i] = st_q[i];
      if (bus.thr_kill[i]) begin
        st_d[i] = FREE;
      end else if (st_q[i] == RUN) begin
        // pause and resume together cancel out
        if (bus.thr_pause && bus.thr_pause_id == TID_W'(i)
            && !bus.thr_resume[i])
          st_d[i] = PAUSED;
      end else if (st_q[i] == PAUSED) begin
        if (bus.thr_resume[i])
          st_d[i] = RUN;
      end else if (st_q[i] == FREE) begin
        if (bus.thr_start && bus.thr_start_id == TID_W'(i))
          st_d[i] = RUN;
      end
    end
  end

  always_comb begin
    nack_d = bus.thr_start &&
             (st_q[bus.thr_start_id] != FREE ||
              bus.thr_kill[bus.thr_start_id]);
  end

  // lowest set bit wins: descending scan lets low indices overwrite
  always_comb begin
    sel_tid = '0;
    sel_hit = 1'b0;
    for (int i = NTHR - 1; i >= 0; i--) begin
      if (bus.L_en[i]) begin
        sel_tid = TID_W'(i);
        sel_hit = 1'b1;
      end
    end
  end

`ifdef RV_SLOT_CHECK_EN
  logic slot_bad;
  logic err_q, err_d;

  always_comb begin
    slot_bad = ($countones(bus.L_en) != 1);
    err_d    = err_q | slot_bad;
  end
`endif

  always_comb begin
    vld_d = sel_hit && (st_q[sel_tid] == RUN);
`ifdef RV_SLOT_CHECK_EN
    if (slot_bad)
      vld_d = 1'b0;
`endif
    tid_d = vld_d ? sel_tid : tid_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHR; i++)
        st_q[i] <= FREE;
      vld_q  <= 1'b0;
      tid_q  <= '0;
      nack_q <= 1'b0;
    end else begin
      for (int i = 0; i < NTHR; i++)
        st_q[i] <= st_d[i];
      vld_q  <= vld_d;
      tid_q  <= tid_d;
      nack_q <= nack_d;
    end
  end

`ifdef RV_SLOT_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else
      err_q <= err_d;
  end

  assign bus.slot_err = err_q;
`endif

  always_comb begin
    for (int i = 0; i < NTHR; i++) begin
      bus.thr_run[i]  = (st_q[i] == RUN);
      bus.thr_busy[i] = (st_q[i] != FREE);
    end
  end

  assign bus.issue_vld  = vld_q;
  assign bus.issue_tid  = tid_q;
  assign bus.start_nack = nack_q;

endmodule

// File: tb/tb_rv_thread_issue.sv
// Directed bench for rv_thread_issue with immediate-assertion checks.
// Covers the RV_SLOT_CHECK_EN build when that macro is defined.
module tb_rv_thread_issue;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rv_thread_issue_if #(.NTHR(8), .TID_W(3)) bus ();

  rv_thread_issue #(.NTHR(8), .TID_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.thr_start    = 1'b0;
    bus.thr_start_id = '0;
    bus.thr_pause    = 1'b0;
    bus.thr_pause_id = '0;
    bus.thr_resume   = '0;
    bus.thr_kill     = '0;
  endtask

  task automatic cyc(input logic [7:0] len);
    bus.L_en = len;
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic chk_iss(input string tag, input logic v,
                         input logic [2:0] t);
    chk({tag, "_vld"}, 32'(bus.issue_vld), 32'(v));
    chk({tag, "_tid"}, 32'(bus.issue_tid), 32'(t));
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    bus.L_en = 8'h00;
    idle();

    // reset with ring moving
    cyc(8'h01);
    cyc(8'h02);
    cyc(8'h04);
    chk_iss("rst", 1'b0, 3'd0);
    chk("rst_busy", 32'(bus.thr_busy), 32'h00);
    chk("rst_run", 32'(bus.thr_run), 32'h00);
    chk("rst_nack", 32'(bus.start_nack), 32'h0);
`ifdef RV_SLOT_CHECK_EN
    chk("rst_err", 32'(bus.slot_err), 32'h0);
`endif
    rst_n = 1'b1;

    // idle rotation
    for (int i = 0; i < 8; i++) begin
      cyc(8'h01 << i);
      chk("idle_vld", 32'(bus.issue_vld), 32'h0);
      chk("idle_busy", 32'(bus.thr_busy), 32'h00);
    end

    // start 3 and 5
    bus.thr_start = 1'b1; bus.thr_start_id = 3'd3;
    cyc(8'h01);
    chk("st3_run", 32'(bus.thr_run), 32'h08);
    bus.thr_start = 1'b1; bus.thr_start_id = 3'd5;
    cyc(8'h02);
    chk("st5_run", 32'(bus.thr_run), 32'h28);
    chk("st5_busy", 32'(bus.thr_busy), 32'h28);
    chk("st5_nack", 32'(bus.start_nack), 32'h0);
    cyc(8'h04); chk_iss("r1_s2", 1'b0, 3'd0);
    cyc(8'h08); chk_iss("r1_s3", 1'b1, 3'd3);
    cyc(8'h10); chk_iss("r1_s4", 1'b0, 3'd3);
    cyc(8'h20); chk_iss("r1_s5", 1'b1, 3'd5);
    cyc(8'h40); chk_iss("r1_s6", 1'b0, 3'd5);
    cyc(8'h80); chk_iss("r1_s7", 1'b0, 3'd5);
    cyc(8'h01); chk_iss("r1_s0", 1'b0, 3'd5);
    cyc(8'h02);
    cyc(8'h04);

    // pause 3 while selected: still issues this slot
    bus.thr_pause = 1'b1; bus.thr_pause_id = 3'd3;
    cyc(8'h08);
    chk_iss("p3_same", 1'b1, 3'd3);
    chk("p3_run", 32'(bus.thr_run), 32'h20);
    chk("p3_busy", 32'(bus.thr_busy), 32'h28);
    cyc(8'h10);
    cyc(8'h20); chk_iss("p3_s5", 1'b1, 3'd5);
    cyc(8'h40);
    cyc(8'h80);
    cyc(8'h01);
    cyc(8'h02);
    cyc(8'h04);
    cyc(8'h08); chk_iss("p3_nxt", 1'b0, 3'd5);

    // resume 3
    bus.thr_resume = 8'h08;
    cyc(8'h10);
    chk("rs3_run", 32'(bus.thr_run), 32'h28);
    cyc(8'h20);
    cyc(8'h40);
    cyc(8'h80);
    cyc(8'h01);
    cyc(8'h02);
    cyc(8'h04);
    cyc(8'h08); chk_iss("rs3_iss", 1'b1, 3'd3);

    // kill + start same cycle on 5
    bus.thr_kill = 8'h20;
    bus.thr_start = 1'b1; bus.thr_start_id = 3'd5;
    cyc(8'h10);
    chk("ks5_run", 32'(bus.thr_run), 32'h08);
    chk("ks5_busy", 32'(bus.thr_busy), 32'h08);
    chk("ks5_nack", 32'(bus.start_nack), 32'h1);
    cyc(8'h20);
    chk("ks5_nack0", 32'(bus.start_nack), 32'h0);
    chk_iss("ks5_iss", 1'b0, 3'd3);

    // start 3 while RUN
    bus.thr_start = 1'b1; bus.thr_start_id = 3'd3;
    cyc(8'h40);
    chk("st3r_nack", 32'(bus.start_nack), 32'h1);
    chk("st3r_run", 32'(bus.thr_run), 32'h08);
    cyc(8'h80);
    chk("st3r_nack0", 32'(bus.start_nack), 32'h0);

    // pause + resume same cycle on 3
    bus.thr_pause = 1'b1; bus.thr_pause_id = 3'd3;
    bus.thr_resume = 8'h08;
    cyc(8'h01);
    chk("pr3_run", 32'(bus.thr_run), 32'h08);

    // pause to FREE thread, resume to RUN thread: ignored
    bus.thr_pause = 1'b1; bus.thr_pause_id = 3'd6;
    bus.thr_resume = 8'h08;
    cyc(8'h02);
    chk("ign_run", 32'(bus.thr_run), 32'h08);
    chk("ign_busy", 32'(bus.thr_busy), 32'h08);

    // L_en = 0
    cyc(8'h00);
    chk_iss("zero", 1'b0, 3'd3);
`ifdef RV_SLOT_CHECK_EN
    chk("zero_err", 32'(bus.slot_err), 32'h1);
    cyc(8'h08);
    chk("err_stky", 32'(bus.slot_err), 32'h1);
    chk_iss("err_good", 1'b1, 3'd3);
`endif

    // multi-hot: thread 4 FREE, thread 3 RUN
    cyc(8'h18);
`ifdef RV_SLOT_CHECK_EN
    chk("mh_vld", 32'(bus.issue_vld), 32'h0);
`else
    chk_iss("mh", 1'b1, 3'd3);
`endif

    // reset mid-rotation
    rst_n = 1'b0;
    cyc(8'h08);
    chk_iss("mrst", 1'b0, 3'd0);
    chk("mrst_run", 32'(bus.thr_run), 32'h00);
    chk("mrst_busy", 32'(bus.thr_busy), 32'h00);
    chk("mrst_nack", 32'(bus.start_nack), 32'h0);
`ifdef RV_SLOT_CHECK_EN
    chk("mrst_err", 32'(bus.slot_err), 32'h0);
`endif
    rst_n = 1'b1;
    cyc(8'h08);
    chk("post_vld", 32'(bus.issue_vld), 32'h0);
`ifdef RV_SLOT_CHECK_EN
    chk("post_err", 32'(bus.slot_err), 32'h0);
    cyc(8'h11);
    chk("h11_err", 32'(bus.slot_err), 32'h1);
    chk("h11_vld", 32'(bus.issue_vld), 32'h0);
    cyc(8'h01);
    chk("h11_stky", 32'(bus.slot_err), 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
